// File: rtl/dff_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Holds the FSM encoding, the delivered-word counter width and the bit-counter width helper.
package dff_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam int WORD_CNT_W = 16;

  // Bit counter must index 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/dff_deser_outreg.sv
// Single-entry output holding register: load has priority, otherwise a handshake empties it.
// dout keeps its last value after a drain so downstream always sees a stable word.
module dff_deser_outreg
  import dff_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             fire
);

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    fire    = valid_q && dout_ready;
    dout_d  = dout_q;
    valid_d = valid_q;
    // A load on the same edge as a drain replaces the word without a bubble.
    if (load) begin
      dout_d  = load_dat;
      valid_d = 1'b1;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/dff_deser.sv
// Deserializer behind the single-bit flop stage: assembles WIDTH-bit words from din.
// A completed word with no free output slot parks in the shifter and drops din_ready.
module dff_deser
  import dff_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        sreg_q, sreg_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic                    accept;
  logic                    slot_free;
  logic                    load;
  logic                    fire;
  logic [WIDTH-1:0]        load_dat;
  logic [WIDTH-1:0]        shifted;

  assign din_ready = (state_q != STALL);
  assign accept    = din_valid && din_ready;
  assign slot_free = !dout_valid || dout_ready;

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {sreg_q[WIDTH-2:0], din};
    end else begin
      shifted = {din, sreg_q[WIDTH-1:1]};
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    load     = 1'b0;
    load_dat = shifted;

    case (state_q)
      IDLE, SHIFT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          sreg_d  = '0;
        end else if (accept) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (slot_free) begin
              load    = 1'b1;
              state_d = IDLE;
              sreg_d  = '0;
            end else begin
              state_d = STALL;
              sreg_d  = shifted;
            end
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_q + CW'(1);
            sreg_d  = shifted;
          end
        end
      end
      // Only the outreg can be occupied here, so dout_ready alone frees it.
      STALL: begin
        if (dout_ready) begin
          load     = 1'b1;
          load_dat = sreg_q;
          state_d  = IDLE;
          sreg_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sreg_d  = '0;
      end
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q + {{(WORD_CNT_W-1){1'b0}}, fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  dff_deser_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_dat  (load_dat),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .fire      (fire)
  );

  assign busy     = (state_q != IDLE);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_dff_deser.sv
// Bench for dff_deser: MSB-first and LSB-first instances share one stimulus stream.
// A word-level model (bit list + pending-word queue) predicts every output each cycle.
module tb_dff_deser;

  logic        clk;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        flush;
  logic        dout_ready;

  logic [7:0]  dout_m, dout_l;
  logic        dout_valid_m, dout_valid_l;
  logic        din_ready_m, din_ready_l;
  logic        busy_m, busy_l;
  logic [15:0] word_cnt_m, word_cnt_l;

  int total = 0;
  int bad   = 0;

  dff_deser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
    .flush(flush), .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .word_cnt(word_cnt_m)
  );

  dff_deser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .flush(flush), .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .word_cnt(word_cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  bit          m_bits[$];
  logic [7:0]  m_q_msb[$];
  logic [7:0]  m_q_lsb[$];
  logic [7:0]  m_last_msb;
  logic [7:0]  m_last_lsb;
  logic [15:0] m_cnt;
  int          m_fires;

  task automatic model_reset();
    m_bits.delete();
    m_q_msb.delete();
    m_q_lsb.delete();
    m_last_msb = 8'h00;
    m_last_lsb = 8'h00;
    m_cnt      = 16'h0000;
  endtask

  // Up to two completed words may be outstanding: one presented, one parked.
  task automatic model_step(input bit dv, input bit d, input bit fl, input bit dr);
    int pend;
    bit rdy;
    logic [7:0] wm, wl;
    pend = m_q_msb.size();
    rdy  = (pend < 2);
    if (pend >= 1 && dr) begin
      m_last_msb = m_q_msb.pop_front();
      m_last_lsb = m_q_lsb.pop_front();
      m_cnt      = m_cnt + 16'd1;
      m_fires++;
    end
    if (fl) begin
      m_bits.delete();
    end else if (dv && rdy) begin
      m_bits.push_back(d);
      if (m_bits.size() == 8) begin
        wm = 8'h00;
        wl = 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (m_bits[i]) begin
            wm = wm | 8'(1 << (7 - i));
            wl = wl | 8'(1 << i);
          end
        end
        m_q_msb.push_back(wm);
        m_q_lsb.push_back(wl);
        m_bits.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    int pend;
    pend = m_q_msb.size();
    chk({tag, ".vld"},   32'(dout_valid_m), 32'(pend >= 1));
    chk({tag, ".vld_l"}, 32'(dout_valid_l), 32'(pend >= 1));
    chk({tag, ".rdy"},   32'(din_ready_m),  32'(pend < 2));
    chk({tag, ".busy"},  32'(busy_m),       32'(m_bits.size() > 0 || pend == 2));
    chk({tag, ".cnt"},   32'(word_cnt_m),   32'(m_cnt));
    chk({tag, ".cnt_l"}, 32'(word_cnt_l),   32'(m_cnt));
    chk({tag, ".dout_m"}, 32'(dout_m), 32'((pend >= 1) ? m_q_msb[0] : m_last_msb));
    chk({tag, ".dout_l"}, 32'(dout_l), 32'((pend >= 1) ? m_q_lsb[0] : m_last_lsb));
  endtask

  // Called at a falling edge: drive, predict, cross one rising edge, compare.
  task automatic cycle(input bit dv, input bit d, input bit fl, input bit dr, input string tag);
    din_valid  = dv;
    din        = d;
    flush      = fl;
    dout_ready = dr;
    model_step(dv, d, fl, dr);
    @(posedge clk);
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dr, input string tag);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) cycle(1'b1, v[i], 1'b0, dr, tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".dout"}, 32'(dout_m),       32'h0);
    chk({tag, ".vld"},  32'(dout_valid_m), 32'h0);
    chk({tag, ".cnt"},  32'(word_cnt_m),   32'h0);
    chk({tag, ".rdy"},  32'(din_ready_m),  32'h1);
    chk({tag, ".busy"}, 32'(busy_m),       32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         dv, d, fl, dr;
    bit         e_vld, e_rdy, e_busy;
    logic [7:0] e_msb, e_lsb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit dv, bit d, bit fl, bit dr, bit vld, bit rdy, bit bsy,
                              logic [7:0] msb, logic [7:0] lsb, logic [15:0] cnt);
    vec_t v;
    v.dv = dv; v.d = d; v.fl = fl; v.dr = dr;
    v.e_vld = vld; v.e_rdy = rdy; v.e_busy = bsy;
    v.e_msb = msb; v.e_lsb = lsb; v.e_cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] pat;
    int start;
    int cyc;

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
    m_fires = 0;
    model_reset();

    // B2 bits with dout_ready=1: valid for exactly one cycle after the 8th bit.
    pat = 8'hB2;
    for (int i = 0; i < 7; i++) add(1, pat[7-i], 0, 1, 0, 1, 1, 8'h00, 8'h00, 16'd0);
    add(1, pat[0], 0, 1, 1, 1, 0, 8'hB2, 8'h4D, 16'd0);
    add(0, 0, 0, 1, 0, 1, 0, 8'hB2, 8'h4D, 16'd1);
    add(0, 0, 0, 0, 0, 1, 0, 8'hB2, 8'h4D, 16'd1);
    // Five bits, flush with a bit on the same edge, then A5 delivered alone.
    for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 0, 1, 1, 8'hB2, 8'h4D, 16'd1);
    add(1, 1, 1, 1, 0, 1, 0, 8'hB2, 8'h4D, 16'd1);
    pat = 8'hA5;
    for (int i = 0; i < 7; i++) add(1, pat[7-i], 0, 1, 0, 1, 1, 8'hB2, 8'h4D, 16'd1);
    add(1, pat[0], 0, 1, 1, 1, 0, 8'hA5, 8'hA5, 16'd1);
    add(0, 0, 0, 1, 0, 1, 0, 8'hA5, 8'hA5, 16'd2);

    repeat (2) @(negedge clk);
    chk_reset_vals("reset_init");
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].dv, vecs[i].d, vecs[i].fl, vecs[i].dr, "tbl_model");
      chk($sformatf("tbl%0d.vld", i),  32'(dout_valid_m), 32'(vecs[i].e_vld));
      chk($sformatf("tbl%0d.rdy", i),  32'(din_ready_m),  32'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d.busy", i), 32'(busy_m),       32'(vecs[i].e_busy));
      chk($sformatf("tbl%0d.msb", i),  32'(dout_m),       32'(vecs[i].e_msb));
      chk($sformatf("tbl%0d.lsb", i),  32'(dout_l),       32'(vecs[i].e_lsb));
      chk($sformatf("tbl%0d.cnt", i),  32'(word_cnt_m),   32'(vecs[i].e_cnt));
    end

    // Asynchronous reset mid-word, asserted between clock edges.
    cycle(1, 1, 0, 0, "midword");
    cycle(1, 0, 0, 0, "midword");
    cycle(1, 1, 0, 0, "midword");
    din_valid = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset_vals("reset_midword");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Backpressure: B2 then 0F with dout_ready low.
    send_byte(8'hB2, 1'b0, "bp");
    chk("bp.first_vld", 32'(dout_valid_m), 32'h1);
    chk("bp.first_dout", 32'(dout_m), 32'hB2);
    pat = 8'h0F;
    for (int i = 7; i >= 1; i--) cycle(1, pat[i], 0, 0, "bp");
    chk("bp.rdy_before_16th", 32'(din_ready_m), 32'h1);
    cycle(1, pat[0], 0, 0, "bp");
    chk("bp.rdy_after_16th", 32'(din_ready_m), 32'h0);
    chk("bp.busy_stall", 32'(busy_m), 32'h1);
    cycle(1, 1, 1, 0, "bp_hold");
    cycle(1, 0, 0, 0, "bp_hold");
    chk("bp.hold_dout", 32'(dout_m), 32'hB2);
    chk("bp.hold_rdy", 32'(din_ready_m), 32'h0);
    cycle(0, 0, 0, 1, "bp_release");
    chk("bp.rel_dout", 32'(dout_m), 32'h0F);
    chk("bp.rel_dout_l", 32'(dout_l), 32'hF0);
    chk("bp.rel_vld", 32'(dout_valid_m), 32'h1);
    chk("bp.rel_rdy", 32'(din_ready_m), 32'h1);
    chk("bp.rel_cnt", 32'(word_cnt_m), 32'd1);
    cycle(0, 0, 0, 1, "bp_drain");
    chk("bp.drain_cnt", 32'(word_cnt_m), 32'd2);
    chk("bp.drain_vld", 32'(dout_valid_m), 32'h0);

    // Reset while stalled discards both held words.
    send_byte(8'h11, 1'b0, "stall2");
    send_byte(8'h22, 1'b0, "stall2");
    chk("stall2.rdy", 32'(din_ready_m), 32'h0);
    #3 rst = 1'b1;
    #1 chk_reset_vals("reset_midstall");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_byte(8'h3C, 1'b1, "post_rst");
    chk("post_rst.dout", 32'(dout_m), 32'h3C);

    // Random gaps, backpressure and occasional flush against the model.
    start = m_fires;
    cyc   = 0;
    while ((m_fires - start) < 1000 && cyc < 40000) begin
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), bit'($urandom_range(0, 1)), "rand");
      cyc++;
    end
    chk("rand.words_delivered", 32'((m_fires - start) >= 1000), 32'h1);
    cycle(0, 0, 1, 1, "rand_tail");
    cycle(0, 0, 1, 1, "rand_tail");
    cycle(0, 0, 1, 1, "rand_tail");

    // Counter wrap: preload near the top, then deliver three words.
    force u_msb.word_cnt_q = 16'hFFFE;
    force u_lsb.word_cnt_q = 16'hFFFE;
    #1;
    release u_msb.word_cnt_q;
    release u_lsb.word_cnt_q;
    m_cnt = 16'hFFFE;
    chk("wrap.preload", 32'(word_cnt_m), 32'hFFFE);
    send_byte(8'h5A, 1'b1, "wrap");
    cycle(0, 0, 0, 1, "wrap");
    chk("wrap.ffff", 32'(word_cnt_m), 32'hFFFF);
    send_byte(8'hC3, 1'b1, "wrap");
    cycle(0, 0, 0, 1, "wrap");
    chk("wrap.zero", 32'(word_cnt_m), 32'h0000);
    send_byte(8'h96, 1'b1, "wrap");
    cycle(0, 0, 0, 1, "wrap");
    chk("wrap.one", 32'(word_cnt_m), 32'h0001);
    chk("wrap.dout", 32'(dout_m), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_deser.md
Name: dff_deser

Overview:
- Serial-to-parallel deserializer directly downstream of the single-bit D flip-flop stage.
- Consumes the registered bit stream from the flop's Q output, one bit per qualified cycle.
- Assembles WIDTH-bit words and presents them on a valid/ready output port.
- Applies backpressure on the serial side when a completed word cannot be handed off.

Parameters:
WIDTH, 8, bits per assembled word (legal range 2..32)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0]

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
din  input  1  serial bit, driven from the upstream flop's Q
din_valid  input  1  din is meaningful this cycle
din_ready  output  1  block accepts din this cycle
flush  input  1  synchronous discard of a partially assembled word
dout  output  WIDTH  assembled word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  downstream accepts dout this cycle
busy  output  1  partial or stalled word present (state != IDLE)
word_cnt  output  16  count of words delivered (dout_valid && dout_ready); wraps 0xFFFF -> 0

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - state=IDLE; bit counter=0; shift register=0.
  - dout=0, dout_valid=0, word_cnt=0, busy=0, din_ready=1.
  - Asserting rst mid-word or mid-stall discards all data with no output.
- Bit acceptance: a bit is accepted on an edge where din_valid && din_ready.
- Shift direction:
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit WIDTH-1.
- Bit counter: 0..WIDTH-1; increments per accepted bit.
- States:
  - IDLE (counter=0, shift register empty):
    - accepted bit -> SHIFT, counter=1.
  - SHIFT:
    - accepted bit with counter<WIDTH-1 -> stay, counter+1.
    - accepted bit with counter=WIDTH-1 completes the word:
      - if output slot free (dout_valid=0, or dout_valid && dout_ready this edge): dout <= completed word, dout_valid=1, go IDLE, counter=0.
      - else go STALL, holding the completed word in the shift register.
  - STALL:
    - din_ready=0.
    - when dout_ready: dout <= shift register, dout_valid stays 1, go IDLE.
- din_ready = (state != STALL). It depends only on registered state, with no combinational path from dout_ready.
- Latency: the last bit accepted at edge N gives dout_valid=1 and the new dout visible after edge N.
- Output handshake:
  - dout_valid and dout are held stable until dout_ready.
  - On dout_valid && dout_ready with no new word arriving: dout_valid drops to 0 and dout keeps its last value.
  - Simultaneous drain and new-word completion: dout_valid stays 1, dout is replaced, no bubble.
- word_cnt increments on every dout_valid && dout_ready edge.
- flush (synchronous):
  - In IDLE/SHIFT: counter=0, shift register=0, state=IDLE; a bit accepted on the same edge is dropped.
  - In STALL: no effect; the completed word is never discarded.
  - dout/dout_valid are never affected by flush.
- din_valid=0 cycles: state is held with no timeout; gaps between bits are allowed.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, SHIFT, STALL);
  - WORD_CNT_W=16 constant;
  - helper function computing the counter width as $clog2(WIDTH).
- One natural sub-module, dff_deser_outreg: single-entry output holding register with valid/ready, load enable and drain logic. The FSM, shifter and counter stay in the top level.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> immediately dout=0, dout_valid=0, word_cnt=0, din_ready=1, busy=0.
- MSB_FIRST=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles, dout_ready=1 -> dout=0xB2, dout_valid high for exactly one cycle after the 8th edge, word_cnt=1.
- MSB_FIRST=0: same bit sequence -> dout=0x4D.
- Backpressure:
  - stream 0xB2 then 0x0F (MSB-first) with dout_ready=0 -> din_ready falls after the 16th accepted bit, dout=0xB2 held.
  - raise dout_ready for one cycle -> dout=0x0F, din_ready=1, word_cnt=1.
- Flush: 5 bits of a word, pulse flush, then 8 bits 0xA5 -> only 0xA5 delivered.
- Gapped input and wrap:
  - din_valid randomly 50% with random dout_ready over 1000 words -> words match a scoreboard in order, no loss or duplication.
  - preload word_cnt=0xFFFF via 65536 words -> wraps to 0.
